mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between EX and WB. Holds one instruction per cycle, waits for the data SRAM response of loads that EX issued, extracts and sign/zero-extends load data, and forwards `ms2ws_bus` / `ms_rf_zip` to WB. It also discards stale SRAM responses after a WB flush (exception or ertn), and drives bypass/stall information toward ID and exception status toward EX.

## Interface
Parameters: none.

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `es2ms_valid`  in  1  EX holds a valid instruction for MEM
- `ms_allowin`  out  1  MEM accepts from EX this cycle
- `es2ms_bus`  in  149  {vaddr[31:0], pc[31:0], except_zip[84:0]}; except_zip[6:0] are exception/ertn flags
- `es_rf_zip`  in  39  {csr_re, rf_we, rf_waddr[4:0], alu_result[31:0]}
- `es_ld_op`  in  5  one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}; 0 = not a load
- `es_mem_req`  in  1  EX's data-SRAM request was accepted (addr_ok) for this instruction
- `data_sram_data_ok`  in  1  response valid
- `data_sram_rdata`  in  32  response data
- `ws_allowin`  in  1  WB accepts
- `ms2ws_valid`  out  1  valid to WB
- `ms2ws_bus`  out  150  {1'b0, vaddr, pc, except_zip}
- `ms_rf_zip`  out  39  {csr_re, rf_we & ms_valid, rf_waddr, final_wdata}
- `ms_ld_block`  out  1  ID must stall on a RAW hit against `rf_waddr`
- `ms_ex`  out  1  ms_valid & |except_zip[6:0]; EX suppresses new stores
- `wb_ex`, `ertn_flush`  in  1 each  flush from WB

## Operation
- Registers: `ms_valid`, payload (bus, rf_zip, ld_op, mem_req), `rdata_got`, `rdata_buf[31:0]`, `drop_cnt[1:0]`.
- `resp_ok` = data_sram_data_ok & (drop_cnt == 0).
- `ms_ready_go` = ~ms_mem_req | rdata_got | resp_ok.
- `ms_allowin` = ~ms_valid | (ms_ready_go & ws_allowin); `ms2ws_valid` = ms_valid & ms_ready_go.
- Payload loads on `es2ms_valid & ms_allowin`. `rdata_got` clears on load.
- `ms_valid`: 0 on reset or flush; else on ms_allowin takes `es2ms_valid`.
- Response capture: on `resp_ok` with `ms_valid & ms_mem_req & ~rdata_got` and not leaving this cycle: `rdata_buf` <= rdata, `rdata_got` <= 1. `raw_rdata` = rdata_got ? rdata_buf : data_sram_rdata.
- Extraction: byte sel = vaddr[1:0]; half sel = vaddr[1]. ld_b/ld_h sign-extend, ld_bu/ld_hu zero-extend, ld_w pass through. `final_wdata` = |ld_op ? extracted : alu_result.
- Drop counter: on flush, drop_cnt <= drop_cnt + (ms_valid & ms_mem_req & ~rdata_got & ~data_sram_data_ok) + (es2ms_valid & es_mem_req) − (data_sram_data_ok & drop_cnt != 0). Otherwise it decrements on each `data_sram_data_ok` while nonzero. It saturates at 3 (≤2 outstanding by design).
- `ms_ld_block` = ms_valid & |ld_op & rf_we & ~(rdata_got | resp_ok) (see Configuration).
- Instructions with except_zip flags never carry mem_req (EX guarantees this). MEM passes them through unchanged.

## Timing
- Reset values: ms_valid=0, rdata_got=0, drop_cnt=0, payload=0. All outputs are 0 out of reset; `ms_allowin`=1.
- Latency: 1 cycle EX→MEM. Non-loads are presented to WB the cycle after acceptance.
- A load advances in the cycle `resp_ok` arrives if ws_allowin=1. The earliest case is the cycle after acceptance.
- Response arriving while ws_allowin=0 is buffered. It must not be lost or re-requested.
- Flush and EX handoff in the same cycle: flush wins; ms_valid=0.
- Flush with data_ok in the same cycle: that response is consumed by the flushed instruction and is not counted in drop_cnt.
- Reset mid-load: all state clears, including drop_cnt.

## Configuration
- `MS_LOAD_FWD_EN` defined: `ms_ld_block` deasserts in the cycle `resp_ok` arrives. `ms_rf_zip` carries the extracted data combinationally from `data_sram_rdata`.
- Undefined: `ms_ld_block` = ms_valid & |ld_op & rf_we for the whole MEM residency. ID waits for the WB bypass. `ms_rf_zip` wdata is still the extracted value.

## Test plan
- ALU op, alu_result=0x1234_5678, rf_waddr=5 → next cycle ms2ws_valid=1, ms_rf_zip={0,1,5,0x12345678}.
- ld_b, vaddr=0x...3, rdata=0x80FF_FF7F, data_ok 2 cycles after acceptance → stall 1 cycle, wdata=0xFFFF_FF80; ld_hu with vaddr[1]=1 → 0x0000_80FF.
- data_ok while ws_allowin=0, released 3 cycles later → WB receives the buffered data once; ms_allowin=0 until release.
- wb_ex while a load awaits data_ok and EX holds an accepted request → drop_cnt=2. The next two data_ok are ignored. The third completes the new load normally.
- except_zip[0]=1 (ale) → ms_ex=1, no wait for data_ok; flush next cycle → ms_valid=0.
- With and without `MS_LOAD_FWD_EN`, load to r7 and data_ok in cycle N → ms_ld_block falls in N (enabled) vs stays high until the load leaves (disabled).

Source files
------------

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
// Bundles every signal mem_stage exchanges with EX, the data SRAM response
// channel and WB. Clock and reset stay plain module ports.
//
// Signal summary:
//   es2ms_valid / ms_allowin             EX -> MEM handshake
//   es2ms_bus[148:0]                     {vaddr, pc, except_zip[84:0]}
//   es_rf_zip[38:0]                      {csr_re, rf_we, rf_waddr, alu_result}
//   es_ld_op[4:0]                        one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}
//   es_mem_req                           EX's SRAM request was accepted
//   data_sram_data_ok / data_sram_rdata  SRAM response
//   ws_allowin / ms2ws_valid             MEM -> WB handshake
//   ms2ws_bus[149:0], ms_rf_zip[38:0]    payload toward WB
//   ms_ld_block                          RAW stall request toward ID
//   ms_ex                                exception in MEM, toward EX
//   wb_ex / ertn_flush                   pipeline flush from WB
//
// Modports:
//   master - the surrounding pipeline (EX, SRAM, WB, ID side)
//   slave  - the mem_stage block itself
// -----------------------------------------------------------------------------
interface mem_stage_if;
  logic         es2ms_valid;
  logic         ms_allowin;
  logic [148:0] es2ms_bus;
  logic [38:0]  es_rf_zip;
  logic [4:0]   es_ld_op;
  logic         es_mem_req;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         ws_allowin;
  logic         ms2ws_valid;
  logic [149:0] ms2ws_bus;
  logic [38:0]  ms_rf_zip;
  logic         ms_ld_block;
  logic         ms_ex;
  logic         wb_ex;
  logic         ertn_flush;

  modport master (
    output es2ms_valid, es2ms_bus, es_rf_zip, es_ld_op, es_mem_req,
           data_sram_data_ok, data_sram_rdata, ws_allowin, wb_ex, ertn_flush,
    input  ms_allowin, ms2ws_valid, ms2ws_bus, ms_rf_zip, ms_ld_block, ms_ex
  );

  modport slave (
    input  es2ms_valid, es2ms_bus, es_rf_zip, es_ld_op, es_mem_req,
           data_sram_data_ok, data_sram_rdata, ws_allowin, wb_ex, ertn_flush,
    output ms_allowin, ms2ws_valid, ms2ws_bus, ms_rf_zip, ms_ld_block, ms_ex
  );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage between EX and WB. Holds one instruction,
// waits for the data-SRAM response of loads issued by EX, extracts and
// sign/zero-extends load data, and hands the result to WB. Responses that
// belong to instructions killed by a WB flush are counted and discarded.
//
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high
//   bus    - mem_stage_if.slave (EX/SRAM/WB/ID signals, see mem_stage_if.sv)
//
// Build option:
//   MS_LOAD_FWD_EN - when defined, ms_ld_block drops in the same cycle the
//                    load response arrives, so ID may take the load result
//                    straight off ms_rf_zip. When undefined, ms_ld_block is
//                    held for the whole MEM residency of a register-writing
//                    load and ID waits for the WB bypass.
// -----------------------------------------------------------------------------
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic         r_ms_valid;
  logic [148:0] r_bus;
  logic [38:0]  r_rf_zip;
  logic [4:0]   r_ld_op;
  logic         r_mem_req;
  logic         r_rdata_got;
  logic [31:0]  r_rdata_buf;
  logic [1:0]   r_drop_cnt;

  // ---------------------------------------------------------------------------
  // Payload field views
  // ---------------------------------------------------------------------------
  logic [31:0] w_vaddr;
  logic [6:0]  w_ex_flags;
  logic        w_csr_re;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_alu_result;

  assign w_vaddr      = r_bus[148:117];
  assign w_ex_flags   = r_bus[6:0];
  assign w_csr_re     = r_rf_zip[38];
  assign w_rf_we      = r_rf_zip[37];
  assign w_rf_waddr   = r_rf_zip[36:32];
  assign w_alu_result = r_rf_zip[31:0];

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic w_flush;
  logic w_resp_ok;
  logic w_ready_go;
  logic w_allowin;
  logic w_accept;
  logic w_leave;
  logic w_waiting;

  assign w_flush    = bus.wb_ex | bus.ertn_flush;
  // A response only belongs to us once every stale response is drained.
  assign w_resp_ok  = bus.data_sram_data_ok & (r_drop_cnt == 2'd0);
  assign w_ready_go = ~r_mem_req | r_rdata_got | w_resp_ok;
  assign w_allowin  = ~r_ms_valid | (w_ready_go & bus.ws_allowin);
  assign w_accept   = bus.es2ms_valid & w_allowin;
  assign w_leave    = r_ms_valid & w_ready_go & bus.ws_allowin;
  // Current instruction still owes us an SRAM response.
  assign w_waiting  = r_ms_valid & r_mem_req & ~r_rdata_got;

  // ---------------------------------------------------------------------------
  // ms_valid and payload
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ms_valid <= 1'b0;
    end else if (w_flush) begin
      // Flush beats a simultaneous EX handoff.
      r_ms_valid <= 1'b0;
    end else if (w_allowin) begin
      r_ms_valid <= bus.es2ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus     <= '0;
      r_rf_zip  <= '0;
      r_ld_op   <= '0;
      r_mem_req <= 1'b0;
    end else if (w_accept) begin
      r_bus     <= bus.es2ms_bus;
      r_rf_zip  <= bus.es_rf_zip;
      r_ld_op   <= bus.es_ld_op;
      r_mem_req <= bus.es_mem_req;
    end
  end

  // ---------------------------------------------------------------------------
  // Response buffer: holds data that arrived while WB was not accepting, so
  // the response is neither lost nor requested again.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata_got <= 1'b0;
      r_rdata_buf <= '0;
    end else if (w_accept) begin
      r_rdata_got <= 1'b0;
    end else if (w_resp_ok & w_waiting & ~w_leave) begin
      r_rdata_got <= 1'b1;
      r_rdata_buf <= bus.data_sram_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Drop counter. On a flush it collects every response still in flight for
  // killed instructions: the one MEM is waiting on (unless it arrives right
  // now, in which case that beat is consumed here) and the one EX already
  // had accepted. At most two can be outstanding; saturation is a guard.
  // ---------------------------------------------------------------------------
  logic       w_inc_ms;
  logic       w_inc_es;
  logic       w_dec;
  logic [2:0] w_drop_sum;
  logic [1:0] w_drop_flush;

  assign w_inc_ms = w_waiting & ~bus.data_sram_data_ok;
  assign w_inc_es = bus.es2ms_valid & bus.es_mem_req;
  assign w_dec    = bus.data_sram_data_ok & (r_drop_cnt != 2'd0);

  // w_dec implies r_drop_cnt >= 1, so the subtraction cannot wrap.
  assign w_drop_sum   = {1'b0, r_drop_cnt} + {2'b00, w_inc_ms}
                      + {2'b00, w_inc_es} - {2'b00, w_dec};
  assign w_drop_flush = (w_drop_sum > 3'd3) ? 2'd3 : w_drop_sum[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= 2'd0;
    end else if (w_flush) begin
      r_drop_cnt <= w_drop_flush;
    end else if (w_dec) begin
      r_drop_cnt <= r_drop_cnt - 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Load data extraction
  // ---------------------------------------------------------------------------
  logic [31:0] w_raw_rdata;
  logic [7:0]  w_byte [4];
  logic [7:0]  w_byte_sel;
  logic [15:0] w_half_sel;
  logic [31:0] w_ld_data;
  logic [31:0] w_final_wdata;

  assign w_raw_rdata = r_rdata_got ? r_rdata_buf : bus.data_sram_rdata;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign w_byte[gi] = w_raw_rdata[8*gi +: 8];
    end
  endgenerate

  assign w_byte_sel = w_byte[w_vaddr[1:0]];
  assign w_half_sel = w_vaddr[1] ? w_raw_rdata[31:16] : w_raw_rdata[15:0];

  // ld_op is one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}.
  always_comb begin
    w_ld_data = w_raw_rdata;
    if (r_ld_op[4]) begin
      w_ld_data = {{24{w_byte_sel[7]}}, w_byte_sel};
    end else if (r_ld_op[3]) begin
      w_ld_data = {24'd0, w_byte_sel};
    end else if (r_ld_op[2]) begin
      w_ld_data = {{16{w_half_sel[15]}}, w_half_sel};
    end else if (r_ld_op[1]) begin
      w_ld_data = {16'd0, w_half_sel};
    end
  end

  assign w_final_wdata = (|r_ld_op) ? w_ld_data : w_alu_result;

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic w_is_rf_load;

  assign w_is_rf_load = r_ms_valid & (|r_ld_op) & w_rf_we;

  assign bus.ms_allowin  = w_allowin;
  assign bus.ms2ws_valid = r_ms_valid & w_ready_go;
  assign bus.ms2ws_bus   = {1'b0, r_bus};
  assign bus.ms_rf_zip   = {w_csr_re, w_rf_we & r_ms_valid, w_rf_waddr, w_final_wdata};
  assign bus.ms_ex       = r_ms_valid & (|w_ex_flags);

`ifdef MS_LOAD_FWD_EN
  // Load data is usable by ID as soon as it reaches MEM.
  assign bus.ms_ld_block = w_is_rf_load & ~(r_rdata_got | w_resp_ok);
`else
  // ID waits until the load has moved on to WB.
  assign bus.ms_ld_block = w_is_rf_load;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed testbench for mem_stage. Inputs change on the falling edge and
// outputs are checked a little after that, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mem_stage_if u_if ();

  mem_stage u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] LD_B  = 5'b10000;
  localparam logic [4:0] LD_BU = 5'b01000;
  localparam logic [4:0] LD_H  = 5'b00100;
  localparam logic [4:0] LD_HU = 5'b00010;
  localparam logic [4:0] LD_W  = 5'b00001;

`ifdef MS_LOAD_FWD_EN
  localparam logic BLOCK_ON_RESP = 1'b0;
`else
  localparam logic BLOCK_ON_RESP = 1'b1;
`endif

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    u_if.es2ms_valid       = 1'b0;
    u_if.es2ms_bus         = '0;
    u_if.es_rf_zip         = '0;
    u_if.es_ld_op          = '0;
    u_if.es_mem_req        = 1'b0;
    u_if.data_sram_data_ok = 1'b0;
    u_if.data_sram_rdata   = '0;
    u_if.ws_allowin        = 1'b1;
    u_if.wb_ex             = 1'b0;
    u_if.ertn_flush        = 1'b0;
  endtask

  // Present a load from EX (call at a falling edge).
  task automatic drive_load(input logic [4:0] op, input logic [31:0] vaddr,
                            input logic [4:0] waddr);
    u_if.es2ms_valid = 1'b1;
    u_if.es2ms_bus   = {vaddr, 32'h1c00_0100, 85'd0};
    u_if.es_rf_zip   = {1'b0, 1'b1, waddr, 32'h0000_0000};
    u_if.es_ld_op    = op;
    u_if.es_mem_req  = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    tick();
    tick();
    #1;
    total++;
    if (u_if.ms_allowin !== 1'b1) begin
      bad++; $display("FAIL reset_allowin got=%b want=1", u_if.ms_allowin);
    end
    total++;
    if (u_if.ms2ws_valid !== 1'b0 || u_if.ms_ex !== 1'b0 || u_if.ms_ld_block !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=%b%b%b want=000",
                      u_if.ms2ws_valid, u_if.ms_ex, u_if.ms_ld_block);
    end
    total++;
    if (u_if.ms2ws_bus !== 150'd0 || u_if.ms_rf_zip !== 39'd0) begin
      bad++; $display("FAIL reset_payload got bus=%h zip=%h want=0", u_if.ms2ws_bus, u_if.ms_rf_zip);
    end
    reset = 1'b0;
    tick();
    $display("reset: allowin=%b valid=%b", u_if.ms_allowin, u_if.ms2ws_valid);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_alu();
    u_if.es2ms_valid = 1'b1;
    u_if.es2ms_bus   = {32'h0000_1000, 32'h1c00_0004, 85'd0};
    u_if.es_rf_zip   = {1'b0, 1'b1, 5'd5, 32'h1234_5678};
    #1;
    total++;
    if (u_if.ms_allowin !== 1'b1) begin
      bad++; $display("FAIL alu_accept got=%b want=1", u_if.ms_allowin);
    end
    tick();
    u_if.es2ms_valid = 1'b0;
    #1;
    total++;
    if (u_if.ms2ws_valid !== 1'b1) begin
      bad++; $display("FAIL alu_valid got=%b want=1", u_if.ms2ws_valid);
    end
    total++;
    if (u_if.ms_rf_zip !== {1'b0, 1'b1, 5'd5, 32'h1234_5678}) begin
      bad++; $display("FAIL alu_rf_zip got=%h want=%h", u_if.ms_rf_zip,
                      {1'b0, 1'b1, 5'd5, 32'h1234_5678});
    end
    total++;
    if (u_if.ms2ws_bus !== {1'b0, 32'h0000_1000, 32'h1c00_0004, 85'd0}) begin
      bad++; $display("FAIL alu_bus got=%h", u_if.ms2ws_bus);
    end
    total++;
    if (u_if.ms_ld_block !== 1'b0 || u_if.ms_ex !== 1'b0) begin
      bad++; $display("FAIL alu_side got=%b%b want=00", u_if.ms_ld_block, u_if.ms_ex);
    end
    tick();
    #1;
    total++;
    if (u_if.ms2ws_valid !== 1'b0) begin
      bad++; $display("FAIL alu_leave got=%b want=0", u_if.ms2ws_valid);
    end
    $display("alu: zip=%h", {1'b0, 1'b1, 5'd5, 32'h1234_5678});
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_extract();
    logic [4:0]  t_op    [7] = '{LD_B, LD_HU, LD_H, LD_BU, LD_W, LD_B, LD_H};
    logic [31:0] t_vaddr [7] = '{32'h1003, 32'h1002, 32'h1000, 32'h1001,
                                 32'h1000, 32'h1000, 32'h1002};
    logic [31:0] t_exp   [7] = '{32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_FF7F,
                                 32'h0000_00FF, 32'h80FF_FF7F, 32'h0000_007F,
                                 32'hFFFF_80FF};
    int          t_lat   [7] = '{2, 1, 1, 1, 1, 1, 3};
    for (int i = 0; i < 7; i++) begin
      drive_load(t_op[i], t_vaddr[i], 5'd7);
      tick();
      u_if.es2ms_valid = 1'b0;
      u_if.es_mem_req  = 1'b0;
      u_if.data_sram_rdata = 32'h5555_AAAA;
      for (int w = 1; w < t_lat[i]; w++) begin
        #1;
        total++;
        if (u_if.ms2ws_valid !== 1'b0 || u_if.ms_allowin !== 1'b0 || u_if.ms_ld_block !== 1'b1) begin
          bad++; $display("FAIL ld%0d_stall got valid=%b allowin=%b block=%b want 0,0,1",
                          i, u_if.ms2ws_valid, u_if.ms_allowin, u_if.ms_ld_block);
        end
        tick();
      end
      u_if.data_sram_data_ok = 1'b1;
      u_if.data_sram_rdata   = 32'h80FF_FF7F;
      #1;
      total++;
      if (u_if.ms2ws_valid !== 1'b1) begin
        bad++; $display("FAIL ld%0d_valid got=%b want=1", i, u_if.ms2ws_valid);
      end
      total++;
      if (u_if.ms_rf_zip !== {1'b0, 1'b1, 5'd7, t_exp[i]}) begin
        bad++; $display("FAIL ld%0d_wdata got=%h want=%h", i, u_if.ms_rf_zip,
                        {1'b0, 1'b1, 5'd7, t_exp[i]});
      end
      total++;
      if (u_if.ms_ld_block !== BLOCK_ON_RESP) begin
        bad++; $display("FAIL ld%0d_block got=%b want=%b", i, u_if.ms_ld_block, BLOCK_ON_RESP);
      end
      tick();
      u_if.data_sram_data_ok = 1'b0;
      #1;
      total++;
      if (u_if.ms2ws_valid !== 1'b0 || u_if.ms_ld_block !== 1'b0) begin
        bad++; $display("FAIL ld%0d_leave got valid=%b block=%b want 0,0",
                        i, u_if.ms2ws_valid, u_if.ms_ld_block);
      end
      $display("load %0d: op=%b vaddr=%h wdata=%h", i, t_op[i], t_vaddr[i], t_exp[i]);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_buffered();
    int wb_count = 0;
    drive_load(LD_W, 32'h2000, 5'd3);
    tick();
    u_if.es2ms_valid       = 1'b0;
    u_if.es_mem_req        = 1'b0;
    u_if.ws_allowin        = 1'b0;
    u_if.data_sram_data_ok = 1'b1;
    u_if.data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    total++;
    if (u_if.ms2ws_valid !== 1'b1 || u_if.ms_allowin !== 1'b0) begin
      bad++; $display("FAIL buf_arrive got valid=%b allowin=%b want 1,0",
                      u_if.ms2ws_valid, u_if.ms_allowin);
    end
    tick();
    u_if.data_sram_data_ok = 1'b0;
    u_if.data_sram_rdata   = 32'h1111_1111;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) u_if.ws_allowin = 1'b1;
      #1;
      total++;
      if (u_if.ms_rf_zip[31:0] !== 32'hDEAD_BEEF || u_if.ms2ws_valid !== 1'b1) begin
        bad++; $display("FAIL buf_hold%0d got wdata=%h valid=%b want deadbeef,1",
                        c, u_if.ms_rf_zip[31:0], u_if.ms2ws_valid);
      end
      total++;
      if (u_if.ms_allowin !== u_if.ws_allowin) begin
        bad++; $display("FAIL buf_allowin%0d got=%b want=%b", c, u_if.ms_allowin, u_if.ws_allowin);
      end
      if (u_if.ms2ws_valid && u_if.ws_allowin) wb_count++;
      tick();
    end
    #1;
    if (u_if.ms2ws_valid && u_if.ws_allowin) wb_count++;
    total++;
    if (wb_count !== 1) begin
      bad++; $display("FAIL buf_once got=%0d want=1", wb_count);
    end
    $display("buffered: wdata=deadbeef handoffs=%0d", wb_count);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_drop();
    drive_load(LD_W, 32'h3000, 5'd8);
    tick();
    // L1 waits; EX holds an accepted request; WB flushes.
    drive_load(LD_W, 32'h3004, 5'd8);
    u_if.wb_ex = 1'b1;
    tick();
    set_idle();
    #1;
    total++;
    if (u_if.ms2ws_valid !== 1'b0 || u_if.ms_allowin !== 1'b1) begin
      bad++; $display("FAIL drop_flush got valid=%b allowin=%b want 0,1",
                      u_if.ms2ws_valid, u_if.ms_allowin);
    end
    // New load accepted while stale response #1 arrives.
    drive_load(LD_W, 32'h3008, 5'd9);
    u_if.data_sram_data_ok = 1'b1;
    u_if.data_sram_rdata   = 32'hAAAA_0001;
    tick();
    u_if.es2ms_valid = 1'b0;
    u_if.es_mem_req  = 1'b0;
    u_if.data_sram_rdata = 32'hAAAA_0002;
    #1;
    total++;
    if (u_if.ms2ws_valid !== 1'b0 || u_if.ms_ld_block !== 1'b1) begin
      bad++; $display("FAIL drop_stale2 got valid=%b block=%b want 0,1",
                      u_if.ms2ws_valid, u_if.ms_ld_block);
    end
    tick();
    u_if.data_sram_data_ok = 1'b0;
    #1;
    total++;
    if (u_if.ms2ws_valid !== 1'b0) begin
      bad++; $display("FAIL drop_idle got=%b want=0", u_if.ms2ws_valid);
    end
    tick();
    u_if.data_sram_data_ok = 1'b1;
    u_if.data_sram_rdata   = 32'h1234_5678;
    #1;
    total++;
    if (u_if.ms2ws_valid !== 1'b1 || u_if.ms_rf_zip !== {1'b0, 1'b1, 5'd9, 32'h1234_5678}) begin
      bad++; $display("FAIL drop_third got valid=%b zip=%h want 1,%h", u_if.ms2ws_valid,
                      u_if.ms_rf_zip, {1'b0, 1'b1, 5'd9, 32'h1234_5678});
    end
    tick();
    set_idle();
    $display("drop: third response %h delivered", 32'h1234_5678);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_except();
    u_if.es2ms_valid = 1'b1;
    u_if.es2ms_bus   = {32'h0000_4001, 32'h1c00_0200, 85'd1};
    u_if.es_rf_zip   = {1'b0, 1'b1, 5'd4, 32'h0000_4001};
    u_if.es_ld_op    = LD_W;
    u_if.es_mem_req  = 1'b0;
    tick();
    u_if.es2ms_valid = 1'b0;
    u_if.ws_allowin  = 1'b0;
    #1;
    total++;
    if (u_if.ms_ex !== 1'b1 || u_if.ms2ws_valid !== 1'b1) begin
      bad++; $display("FAIL exc_flag got ex=%b valid=%b want 1,1", u_if.ms_ex, u_if.ms2ws_valid);
    end
    u_if.ertn_flush = 1'b1;
    tick();
    set_idle();
    #1;
    total++;
    if (u_if.ms2ws_valid !== 1'b0 || u_if.ms_ex !== 1'b0 || u_if.ms_allowin !== 1'b1) begin
      bad++; $display("FAIL exc_flush got valid=%b ex=%b allowin=%b want 0,0,1",
                      u_if.ms2ws_valid, u_if.ms_ex, u_if.ms_allowin);
    end
    $display("except: ms_ex seen, flushed");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush_corners();
    // Flush and EX handoff together: flush wins.
    u_if.es2ms_valid = 1'b1;
    u_if.es_rf_zip   = {1'b0, 1'b1, 5'd2, 32'h0000_00AA};
    u_if.wb_ex       = 1'b1;
    tick();
    set_idle();
    #1;
    total++;
    if (u_if.ms2ws_valid !== 1'b0) begin
      bad++; $display("FAIL flush_handoff got=%b want=0", u_if.ms2ws_valid);
    end
    // Flush with data_ok together: that response is not counted as stale.
    drive_load(LD_W, 32'h5000, 5'd6);
    tick();
    set_idle();
    u_if.wb_ex = 1'b1;
    u_if.data_sram_data_ok = 1'b1;
    u_if.data_sram_rdata   = 32'hBBBB_0000;
    tick();
    set_idle();
    drive_load(LD_W, 32'h5004, 5'd6);
    tick();
    u_if.es2ms_valid = 1'b0;
    u_if.es_mem_req  = 1'b0;
    u_if.data_sram_data_ok = 1'b1;
    u_if.data_sram_rdata   = 32'hCAFE_0001;
    #1;
    total++;
    if (u_if.ms2ws_valid !== 1'b1 || u_if.ms_rf_zip[31:0] !== 32'hCAFE_0001) begin
      bad++; $display("FAIL flush_dataok got valid=%b wdata=%h want 1,cafe0001",
                      u_if.ms2ws_valid, u_if.ms_rf_zip[31:0]);
    end
    tick();
    set_idle();
    // Reset mid-load with two responses pending clears the drop counter.
    drive_load(LD_W, 32'h6000, 5'd1);
    tick();
    drive_load(LD_W, 32'h6004, 5'd1);
    u_if.wb_ex = 1'b1;
    tick();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive_load(LD_W, 32'h6008, 5'd1);
    tick();
    u_if.es2ms_valid = 1'b0;
    u_if.es_mem_req  = 1'b0;
    u_if.data_sram_data_ok = 1'b1;
    u_if.data_sram_rdata   = 32'h0BAD_F00D;
    #1;
    total++;
    if (u_if.ms2ws_valid !== 1'b1 || u_if.ms_rf_zip[31:0] !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL reset_drop got valid=%b wdata=%h want 1,0badf00d",
                      u_if.ms2ws_valid, u_if.ms_rf_zip[31:0]);
    end
    tick();
    set_idle();
    $display("flush corners: handoff dropped, dataok consumed, reset cleared");
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    set_idle();
    @(negedge clk);
    test_reset();
    test_alu();
    test_extract();
    test_buffered();
    test_drop();
    test_except();
    test_flush_corners();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
